// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall unit.
package hazard_pkg;

  localparam int         CNT_W    = 4;
  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  // True when a non-x0 destination feeds either source operand.
  function automatic logic reg_match(input logic [4:0] rd,
                                     input logic [4:0] rs1,
                                     input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_cycle_counter.sv
// Remaining-stall counter for multi-cycle multiply/divide residency in ID.
module md_cycle_counter
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Clear beats load beats decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / multiply-divide stall and branch flush generator (outputs are Mealy).
// Optional perf counters (stall_count, flush_count) enabled by HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_e,
  input  logic        load_e,
  input  logic [4:0]  rd_m1,
  input  logic        load_m1,
  input  logic        muldiv_d,
  input  logic        div_d,
  input  logic        pc_src_e,
  output logic        stall_f,
  output logic        stall_d,
  output logic        bubble_e,
  output logic        flush_d,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_count,
  output logic [31:0] flush_count,
`endif
  output logic        md_busy
);

  localparam logic [4:0] MUL_N = 5'(MUL_CYCLES);
  localparam logic [4:0] DIV_N = 5'(DIV_CYCLES);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             lu_s;
  logic [4:0]       n_s;
  logic [CNT_W-1:0] cnt_ld_val_s;
  logic             cnt_zero_s;
  logic             cnt_ld_s;
  logic             cnt_dec_s;
  logic             cnt_clr_s;
  logic             stall_s;
  logic             bubble_s;
  logic             flush_s;

  assign lu_s = (load_e  && reg_match(rd_e,  rs1_d, rs2_d)) ||
                (load_m1 && reg_match(rd_m1, rs1_d, rs2_d));
  assign n_s          = div_d ? DIV_N : MUL_N;
  // First residency cycle is spent in IDLE and the release cycle needs cnt==0.
  assign cnt_ld_val_s = CNT_W'(n_s - 5'd2);

  md_cycle_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_ld_s),
    .load_val (cnt_ld_val_s),
    .dec      (cnt_dec_s),
    .clr      (cnt_clr_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, counter control and Mealy outputs.
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    flush_s     = 1'b0;
    cnt_ld_s    = 1'b0;
    cnt_dec_s   = 1'b0;
    cnt_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (pc_src_e) begin
          flush_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (lu_s) begin
          stall_s  = 1'b1;
          bubble_s = 1'b1;
        end else if (muldiv_d && (n_s >= 5'd2)) begin
          stall_s     = 1'b1;
          bubble_s    = 1'b1;
          cnt_ld_s    = 1'b1;
          state_nxt_s = MD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MD_WAIT: begin
        if (pc_src_e) begin
          flush_s     = 1'b1;
          bubble_s    = 1'b1;
          cnt_clr_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (!cnt_zero_s) begin
          stall_s   = 1'b1;
          bubble_s  = 1'b1;
          cnt_dec_s = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  assign stall_f  = stall_s;
  assign stall_d  = stall_s;
  assign bubble_e = bubble_s;
  assign flush_d  = flush_s;
  assign md_busy  = (state_r == MD_WAIT);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_r;
  logic [31:0] flush_count_r;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_r <= 32'd0;
      flush_count_r <= 32'd0;
    end else begin
      stall_count_r <= stall_count_r + {31'd0, stall_s};
      flush_count_r <= flush_count_r + {31'd0, flush_s};
    end
  end

  assign stall_count = stall_count_r;
  assign flush_count = flush_count_r;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: cycle-level residency model plus directed literals.
module tb_hazard_stall_unit;
  import hazard_pkg::*;

  localparam int MUL_N = 3;
  localparam int DIV_N = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_d = 5'd0, rs2_d = 5'd0, rd_e = 5'd0, rd_m1 = 5'd0;
  logic       load_e = 1'b0, load_m1 = 1'b0, muldiv_d = 1'b0, div_d = 1'b0, pc_src_e = 1'b0;
  logic       stall_f, stall_d, bubble_e, flush_d, md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count, flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hazard_stall_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_e(rd_e),
    .load_e(load_e), .rd_m1(rd_m1), .load_m1(load_m1), .muldiv_d(muldiv_d),
    .div_d(div_d), .pc_src_e(pc_src_e), .stall_f(stall_f), .stall_d(stall_d),
    .bubble_e(bubble_e), .flush_d(flush_d),
`ifdef HAZARD_PERF_CNT_EN
    .stall_count(stall_count), .flush_count(flush_count),
`endif
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The muldiv in ID is described by its residency window [md_start, md_end]:
  // it stalls every cycle before md_end and is "busy" after its first cycle.
  int  cyc = 0;
  int  md_start = -1;
  int  md_end = -1;
  int  e_sc = 0, e_fc = 0;
  logic e_stall, e_flush, e_bubble, e_busy, m_lu;

  always @(negedge clk) begin
    int n;
    cyc++;
    if (!rst_n) begin
      md_start = -1; md_end = -1; e_sc = 0; e_fc = 0;
    end
    n = div_d ? DIV_N : MUL_N;
    m_lu = (load_e  && rd_e  != 5'd0 && (rd_e  == rs1_d || rd_e  == rs2_d)) ||
           (load_m1 && rd_m1 != 5'd0 && (rd_m1 == rs1_d || rd_m1 == rs2_d));
    e_busy = (cyc > md_start) && (cyc <= md_end);
    e_flush = pc_src_e;
    if (e_busy) begin
      e_stall = !pc_src_e && (cyc < md_end);
    end else begin
      e_stall = !pc_src_e && (m_lu || (muldiv_d && n >= 2));
    end
    e_bubble = e_flush || e_stall;

    check("stall_f",  {31'd0, stall_f},  {31'd0, e_stall});
    check("stall_d",  {31'd0, stall_d},  {31'd0, e_stall});
    check("bubble_e", {31'd0, bubble_e}, {31'd0, e_bubble});
    check("flush_d",  {31'd0, flush_d},  {31'd0, e_flush});
    check("md_busy",  {31'd0, md_busy},  {31'd0, e_busy});
`ifdef HAZARD_PERF_CNT_EN
    check("stall_count", stall_count, e_sc);
    check("flush_count", flush_count, e_fc);
`endif

    if (rst_n) begin
      if (e_busy && pc_src_e) md_end = cyc;
      else if (!e_busy && !pc_src_e && !m_lu && muldiv_d && n >= 2) begin
        md_start = cyc;
        md_end   = cyc + n - 1;
      end
      e_sc += int'(e_stall);
      e_fc += int'(e_flush);
    end
  end

  // ---------------- directed stimulus ----------------
  logic s_stall, s_flush, s_busy;

  // One cycle: apply inputs, sample outputs at the falling edge, leave 1 after next rise.
  task automatic step(input logic [4:0] r1, input logic [4:0] r2,
                      input logic [1:0] res_src_e, input logic [4:0] re,
                      input logic lm, input logic [4:0] rm,
                      input logic md, input logic dv, input logic pc);
    rs1_d = r1; rs2_d = r2; rd_e = re; load_e = (res_src_e == RES_LOAD);
    load_m1 = lm; rd_m1 = rm; muldiv_d = md; div_d = dv; pc_src_e = pc;
    @(negedge clk);
    s_stall = stall_d; s_flush = flush_d; s_busy = md_busy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  int nst, nbz;

  initial begin
    #3;
    check("reset_stall", {31'd0, stall_d}, 32'd0);
    check("reset_busy",  {31'd0, md_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();

    // Divide N=8: seven stall cycles, busy on the following seven cycles.
    nst = 0; nbz = 0;
    for (int i = 0; i < 8; i++) begin
      step(5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      nst += int'(s_stall); nbz += int'(s_busy);
      if (i == 0) check("div_busy_t", {31'd0, s_busy}, 32'd0);
      if (i == 7) check("div_release_stall", {31'd0, s_stall}, 32'd0);
    end
    check("div_stall_cycles", nst, 32'd7);
    check("div_busy_cycles",  nbz, 32'd7);
    idle();
    check("div_idle_t8", {31'd0, s_busy}, 32'd0);
    step(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("flush_idle", {31'd0, s_flush}, 32'd1);
    idle();
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_count", stall_count, 32'd7);
    check("perf_flush_count", flush_count, 32'd1);
`endif

    // Load-use against EX then MEM1.
    step(5'd5, 5'd9, 2'b01, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_ex_t", {31'd0, s_stall}, 32'd1);
    step(5'd5, 5'd9, 2'b00, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    check("lu_ex_t1", {31'd0, s_stall}, 32'd1);
    step(5'd5, 5'd9, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_ex_t2", {31'd0, s_stall}, 32'd0);
    step(5'd0, 5'd9, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_x0", {31'd0, s_stall}, 32'd0);
    step(5'd3, 5'd9, 2'b10, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("non_load", {31'd0, s_stall}, 32'd0);
    step(5'd3, 5'd9, 2'b01, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("flush_over_lu", {31'd0, s_stall}, 32'd0);
    idle();

    // Divide aborted by a taken branch at t+3.
    for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    step(5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
    check("abort_flush", {31'd0, s_flush}, 32'd1);
    check("abort_stall", {31'd0, s_stall}, 32'd0);
    idle();
    check("abort_idle", {31'd0, s_busy}, 32'd0);

    // Load-use coincident with a multiply: 2 + (MUL_N-1) stall cycles.
    nst = 0;
    step(5'd1, 5'd7, 2'b01, 5'd7, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); nst += int'(s_stall);
    step(5'd1, 5'd7, 2'b00, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0); nst += int'(s_stall);
    for (int i = 0; i < 3; i++) begin
      step(5'd1, 5'd7, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      nst += int'(s_stall);
    end
    check("lu_mul_release", {31'd0, s_stall}, 32'd0);
    check("lu_mul_stalls", nst, 32'd4);
    idle();

    // Asynchronous reset in the middle of a divide.
    for (int i = 0; i < 3; i++) step(5'd1, 5'd2, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    check("pre_reset_busy", {31'd0, md_busy}, 32'd1);
    muldiv_d = 1'b0; div_d = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy",  {31'd0, md_busy}, 32'd0);
    check("async_reset_stall", {31'd0, stall_d}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle();
    check("post_reset_stall", {31'd0, s_stall}, 32'd0);
    check("post_reset_busy",  {31'd0, s_busy},  32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and flush generator for the six-stage pipeline (IF, ID, EX, MEM1, MEM2, WB). It is the producer side of the controller's `SS2` bubble input: it detects load-use hazards and holds multi-cycle multiply/divide instructions in ID. It drives the fetch/decode stall enables and the EX bubble, and flushes ID on a taken branch or jump.

## Interface
Parameters:
- `MUL_CYCLES`, default 3: total ID residency of a multiply, in cycles. Legal range 1..16.
- `DIV_CYCLES`, default 8: total ID residency of a divide, in cycles. Legal range 1..16.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rs1_d`, `rs2_d`  in  5  source registers of the instruction in ID.
- `rd_e`  in  5  destination register of the instruction in EX.
- `load_e`  in  1  EX holds a load (`ResultSrc==01`).
- `rd_m1`  in  5  destination register of the instruction in MEM1.
- `load_m1`  in  1  MEM1 holds a load.
- `muldiv_d`  in  1  ID holds an M-extension op (`op==0110011`, `funct7[0]==1`).
- `div_d`  in  1  that op is a divide or remainder (`funct3[2]==1`).
- `pc_src_e`  in  1  taken branch or jump resolved in EX.
- `stall_f`  out  1  hold PC.
- `stall_d`  out  1  hold IF/ID register.
- `bubble_e`  out  1  to controller `SS2`; zeroes EX control.
- `flush_d`  out  1  clear IF/ID register.
- `md_busy`  out  1  FSM is in MD_WAIT.

## Operation
- FSM states: IDLE and MD_WAIT. There is a 4-bit remaining-stall counter `cnt`.
- Load-use hazard `lu`: (`load_e` and `rd_e`≠0 and `rd_e`∈{`rs1_d`,`rs2_d`}) or (`load_m1` and `rd_m1`≠0 and `rd_m1`∈{`rs1_d`,`rs2_d`}).
  - A match against EX stalls for 2 cycles total: the load advances to MEM1 and is caught again there.
- Let N be `DIV_CYCLES` if `div_d`, else `MUL_CYCLES`.
- Priority in IDLE:
  1. `pc_src_e`: `flush_d`=1 and `bubble_e`=1. No stall. Stay in IDLE.
  2. `lu`: `stall_f`=`stall_d`=`bubble_e`=1. Stay in IDLE. A pending muldiv start is deferred.
  3. `muldiv_d` and N≥2: `stall_f`=`stall_d`=`bubble_e`=1, `cnt`<=N-2, go to MD_WAIT.
  4. Otherwise all outputs are 0.
- In MD_WAIT:
  - `pc_src_e`: `flush_d`=1, `bubble_e`=1, no stall, go to IDLE, `cnt`<=0. The muldiv op is aborted.
  - `cnt`≠0: stall/bubble asserted, `cnt`<=`cnt`-1.
  - `cnt`==0: no stall, go to IDLE. `muldiv_d` is ignored this cycle so the same instruction does not restart.
- Load-use cannot arise in MD_WAIT because bubbles drain EX/MEM1. `lu` is ignored there.
- All outputs are Mealy (combinational from state, `cnt` and inputs). There is no registered output path.

## Timing
- Reset: state=IDLE, `cnt`=0. Outputs follow IDLE combinational rules; with inputs at 0, all outputs are 0.
- Reset asserted mid-MD_WAIT returns the FSM to IDLE immediately and asynchronously.
- A muldiv op entering ID at cycle t with no hazard stalls cycles t..t+N-2 (N-1 cycles). It advances to EX at the end of cycle t+N-1.
- N=1: no stall and no state change.
- Load-use EX match at cycle t: stall at t and t+1, released at t+2.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - Adds output `stall_count` (32 bits) and `flush_count` (32 bits).
  - `stall_count` increments each cycle `stall_d`=1. `flush_count` increments each cycle `flush_d`=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- `hazard_pkg`: state enum (IDLE, MD_WAIT), `CNT_W`=4, `RES_LOAD`=2'b01.
- One sub-module, `md_cycle_counter`: load/decrement/zero-detect for `cnt`.

## Test plan
- Load at EX with `rd_e`=5, `rs1_d`=5: stall/bubble high 2 cycles, then 0. With `rd_e`=0: no stall.
- `muldiv_d`=1, `div_d`=1, `DIV_CYCLES`=8: stall exactly 7 cycles, `md_busy` high cycles t+1..t+7, idle at t+8.
- `pc_src_e` at cycle t+3 of a divide: `flush_d`=1, stall 0, FSM IDLE at t+4.
- Load-use and `muldiv_d` simultaneous: 2 load-use stall cycles, then `MUL_CYCLES`-1 muldiv stall cycles.
- `rst_n` low during MD_WAIT: `md_busy`=0 without waiting for a clock edge; after release, outputs are 0 with idle inputs.
- With `HAZARD_PERF_CNT_EN`: one divide (N=8) plus one flush gives `stall_count`=7 and `flush_count`=1.
